interrupt_arbiter: RTL
======================

# interrupt_arbiter

Parametrised interrupt arbiter that collects `NUM_IRQ` edge-triggered interrupt sources into a single CPU interrupt line and publishes the ID of the source being serviced. It replaces the fixed four-input interrupt extender in the IO subsystem. It latches every rising edge into a pending register, so simultaneous interrupts are queued and never dropped. It dispatches one source at a time in fixed priority order and holds off the next dispatch until the CPU acknowledges the current one.

## Interface
- `NUM_IRQ`, 8: number of interrupt sources; legal range 1..255.
- `ACK_TIMEOUT`, 1024: cycles to wait for `i_ack` before auto-release; used only when the timeout feature is compiled in; must be ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_irq`  in  NUM_IRQ  interrupt sources; rising-edge triggered, synchronous to `clk`.
- `i_mask`  in  NUM_IRQ  per-source enable; 1 = may dispatch.
- `i_ack`  in  1  CPU end-of-handler strobe.
- `o_int`  out  1  one-cycle interrupt pulse to CPU.
- `o_int_id`  out  32  ID of the dispatched source (index+1); 0 = none since reset.
- `o_pending`  out  NUM_IRQ  current pending bits, for status readback.
- `o_busy`  out  1  high while a dispatched interrupt awaits `i_ack`.

## Operation
- Edge detect: `irq_q` registers `i_irq`; rise = `i_irq & ~irq_q`. `irq_q` resets to 0, so a source already high when reset releases counts as one edge.
- Pending: `pending <= (pending & ~clr) | rise`. If a rise and a clear hit the same bit in one cycle, the set wins.
- Eligible = `pending & i_mask`. Masked pending bits are retained and dispatch once unmasked.
- Priority: lowest index wins; index 0 maps to ID 1.
- ID arithmetic: `o_int_id` = winning index + 1, zero-extended to 32 bits.
- State machine:
  - IDLE: if eligible ≠ 0, latch the ID, clear that pending bit, go to FIRE. Otherwise stay in IDLE.
  - FIRE: `o_int` = 1 for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: `o_busy` = 1. `i_ack` moves to IDLE. New edges keep accumulating in `pending`.
- `i_ack` in IDLE or FIRE is ignored. An ack is never stored.
- `o_int_id` holds its value until the next dispatch. It stays valid throughout the handler and after it.
- Reset values: `o_int` = 0, `o_int_id` = 0, `o_pending` = 0, `o_busy` = 0, state = IDLE, `irq_q` = 0.
- Reset asserted mid-operation aborts immediately to the reset values and discards all pending bits.

## Timing
- Edge at `i_irq` sampled at clock edge k → pending bit visible after edge k.
- Dispatch decision at edge k+1 → `o_int_id` updated and `o_int` high in cycle k+1..k+2.
- WAIT_ACK is entered after edge k+2. Latency from sampling edge to `o_int` rising is 1 cycle, from an idle arbiter.
- `i_ack` sampled at edge a → IDLE after edge a. The next dispatch occurs at edge a+1 at the earliest.
- Minimum spacing between `o_int` pulses is therefore 3 cycles.
- A repeat edge on the source currently in service re-sets its pending bit and is dispatched again after ack.
- `o_pending` and `o_busy` are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `INTERRUPT_ARBITER_ACK_TIMEOUT_EN`.
- Defined: a counter runs in WAIT_ACK.
  - After `ACK_TIMEOUT` cycles without `i_ack`, the arbiter returns to IDLE as if acked.
  - The counter clears on entering WAIT_ACK.
  - An `i_ack` on the same cycle as expiry is treated as a normal ack.
- Not defined: no counter is built, and WAIT_ACK waits for `i_ack` indefinitely.

## Test plan
- Reset release with all inputs low → every output 0. Pulse `i_irq[3]` high for 1 cycle with `i_mask` = all ones → `o_int` pulses once, `o_int_id` = 4, `o_busy` = 1 until `i_ack`.
- `i_irq[1]` and `i_irq[5]` rise on the same edge → dispatch ID 2; after ack, dispatch ID 6; after the second ack, `o_pending` = 0. No event is lost.
- `i_mask[2]` = 0, then pulse `i_irq[2]` → no `o_int` and `o_pending[2]` = 1. Set `i_mask[2]` = 1 → `o_int` with ID 3 one cycle later.
- Edge on `i_irq[0]` during WAIT_ACK for ID 5 → no `o_int` before ack. After ack, ID 1 is dispatched. `i_ack` pulsed in IDLE has no effect.
- Assert `reset` in WAIT_ACK with `pending` = 0x0A → all outputs and pending return to 0 asynchronously, before the next `clk` edge.
- Timeout build, `ACK_TIMEOUT` = 16, no ack → `o_busy` falls 16 cycles after entering WAIT_ACK and the next pending source dispatches. Non-timeout build → `o_busy` stays high for 1000 cycles.

Source files
------------

// File: rtl/interrupt_arbiter_if.sv
// Bus bundle for interrupt_arbiter: interrupt sources, masks and the CPU-side
// pulse/ID/status signals. The master drives the sources; the arbiter is the slave.
interface interrupt_arbiter_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] i_irq;
    logic [NUM_IRQ-1:0] i_mask;
    logic               i_ack;
    logic               o_int;
    logic [31:0]        o_int_id;
    logic [NUM_IRQ-1:0] o_pending;
    logic               o_busy;

    modport master (
        output i_irq, i_mask, i_ack,
        input  o_int, o_int_id, o_pending, o_busy
    );

    modport slave (
        input  i_irq, i_mask, i_ack,
        output o_int, o_int_id, o_pending, o_busy
    );
endinterface

// File: rtl/interrupt_arbiter.sv
// Fixed-priority edge-triggered interrupt arbiter with ack handshake.
// Define INTERRUPT_ARBITER_ACK_TIMEOUT_EN to auto-release WAIT_ACK after ACK_TIMEOUT cycles.
module interrupt_arbiter #(
    parameter int NUM_IRQ     = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    interrupt_arbiter_if.slave bus
);
    if (NUM_IRQ < 1 || NUM_IRQ > 255) begin : g_bad_num_irq
        $error("NUM_IRQ out of range");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [31:0]        int_id_q, int_id_d;
    logic               int_q, int_d;
    logic               busy_q, busy_d;

    logic [NUM_IRQ-1:0] rise, eligible, win_oh, clr;
    logic [7:0]         win_idx;
    logic               win_found;
    logic               expired;

`ifdef INTERRUPT_ARBITER_ACK_TIMEOUT_EN
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign expired = (cnt_q == CW'(ACK_TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    assign rise     = bus.i_irq & ~irq_q;
    assign eligible = pending_q & bus.i_mask;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = i[7:0];
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        int_d    = 1'b0;
        busy_d   = busy_q;
        clr      = '0;
        irq_d    = bus.i_irq;
`ifdef INTERRUPT_ARBITER_ACK_TIMEOUT_EN
        cnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    int_id_d = 32'(win_idx) + 32'd1;
                    clr      = win_oh;
                    int_d    = 1'b1;
                    state_d  = FIRE;
                end
            end
            FIRE: begin
                busy_d  = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.i_ack || expired) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef INTERRUPT_ARBITER_ACK_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A rise on the bit being cleared this cycle wins.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            int_id_q  <= '0;
            int_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef INTERRUPT_ARBITER_ACK_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            int_id_q  <= int_id_d;
            int_q     <= int_d;
            busy_q    <= busy_d;
`ifdef INTERRUPT_ARBITER_ACK_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.o_int     = int_q;
    assign bus.o_int_id  = int_id_q;
    assign bus.o_pending = pending_q;
    assign bus.o_busy    = busy_q;
endmodule
